// File: rtl/reg8_rr_write_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit configuration register.
// Latency: grant is combinational; q, owner_id and wr_strobe update one cycle after the transfer edge.
// Backpressure: requesters hold req_valid/req_data until granted; losers, or non-owners while locked, get no grant.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   req_valid/lock/data   - per-requester write request, lock request and data (requester i at [i*WIDTH +: WIDTH])
//   grant                 - one-hot combinational grant; transfer = req_valid[i] & grant[i] at the rising edge
//   q                     - shared register value
//   wr_strobe             - one-cycle pulse after every transfer
//   owner_id              - index of last writer / current lock owner
//   locked                - high while a requester holds the lock
//   lock_timeout          - one-cycle pulse when an idle lock is forcibly released
// Optional build macro: ARB_LOCK_TIMEOUT_EN enables the idle-lock timeout counter.
// Without it, lock_timeout is tied low and a lock is held until its owner releases it.

module reg8_rr_write_arbiter #(
    parameter int              NUM_REQ      = 4,
    parameter int              WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = WIDTH'('h34),
    parameter int              LOCK_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [WIDTH-1:0]           q,
    output logic                       wr_strobe,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner_id,
    output logic                       locked,
    output logic                       lock_timeout
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;

    logic            found;      // a transfer happens on the next edge
    logic [OW-1:0]   win;        // index of the granted requester
    logic [OW-1:0]   win_next;   // (win + 1) mod NUM_REQ
    logic [WIDTH-1:0] win_data;
    int              idx;

    // Winner selection. While locked, owner_id doubles as the lock owner,
    // since only the owner can write until the lock is dropped.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (state == LOCKED) begin
            win   = owner_id;
            found = req_valid[owner_id];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = OW'(idx);
                end
            end
        end
    end

    always_comb begin
        grant    = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && (win == OW'(i))) begin
                grant[i] = 1'b1;
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign win_next = (int'(win) == NUM_REQ - 1) ? '0 : win + OW'(1);
    assign locked   = (state == LOCKED);

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

    logic [CW-1:0] lock_cnt;
    logic          lock_timeout_r;

    assign lock_timeout = lock_timeout_r;
`else
    logic unused_lock_timeout_cfg;

    assign unused_lock_timeout_cfg = (LOCK_TIMEOUT > 0);
    assign lock_timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            q         <= RESET_VAL;
            wr_strobe <= 1'b0;
            owner_id  <= '0;
`ifdef ARB_LOCK_TIMEOUT_EN
            lock_cnt       <= '0;
            lock_timeout_r <= 1'b0;
`endif
        end else begin
            wr_strobe <= found;
`ifdef ARB_LOCK_TIMEOUT_EN
            lock_timeout_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        q        <= win_data;
                        owner_id <= win;
                        ptr      <= win_next;
                        if (req_lock[win]) begin
                            state <= LOCKED;
`ifdef ARB_LOCK_TIMEOUT_EN
                            lock_cnt <= '0;
`endif
                        end
                    end
                end
                LOCKED: begin
                    if (found) begin
                        // Owner write; keeping lock high extends the lock.
                        q <= win_data;
`ifdef ARB_LOCK_TIMEOUT_EN
                        lock_cnt <= '0;
`endif
                        if (!req_lock[win]) begin
                            state <= IDLE;
                            ptr   <= win_next;
                        end
                    end else if (!req_lock[owner_id]) begin
                        // Owner gave the lock back without writing: pointer kept.
                        state <= IDLE;
                    end else begin
`ifdef ARB_LOCK_TIMEOUT_EN
                        if (lock_cnt == CNT_LAST) begin
                            state          <= IDLE;
                            ptr            <= win_next;
                            lock_timeout_r <= 1'b1;
                            lock_cnt       <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + CW'(1);
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reg8_rr_write_arbiter.md
Name: reg8_rr_write_arbiter

Overview:
Round-robin write arbiter that owns and shares one WIDTH-bit configuration register between NUM_REQ requesters. Each requester presents a write through a valid/grant handshake. A requester can lock the register for a multi-write sequence. The block holds the register, which resets to RESET_VAL (8'h34 default), and sits between configuration masters and the datapath that consumes q.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
WIDTH, 8, register width in bits
RESET_VAL, 8'h34, value loaded into q on reset
LOCK_TIMEOUT, 64, cycles a lock may idle before forced release (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_lock  in  NUM_REQ  per-requester lock request, qualified with valid at transfer
req_data  in  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
grant  out  NUM_REQ  one-hot combinational grant; transfer = req_valid[i] & grant[i] at rising edge
q  out  WIDTH  shared register value
wr_strobe  out  1  registered pulse, high for one cycle after each transfer
owner_id  out  clog2(NUM_REQ) (min 1)  index of last writer or lock owner
locked  out  1  high while in LOCKED state
lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). These are fixed.
- Reset values: q=RESET_VAL, grant=0, wr_strobe=0, owner_id=0, locked=0, lock_timeout=0, state=IDLE, rr pointer=0.
- Reset overrides everything, including mid-lock. A transfer coinciding with reset is discarded.
- States: IDLE and LOCKED.
- IDLE: grant goes to the first requester with req_valid=1 when searching from the pointer upward, wrapping NUM_REQ-1 to 0. grant=0 if no valid.
- Grant is a function of registered state and current req_valid only. It never depends on req_data or req_lock.
- Transfer at edge:
  - q <= winner data.
  - wr_strobe=1 in the following cycle.
  - owner_id <= winner.
  - pointer <= (winner+1) mod NUM_REQ.
  - If req_lock[winner]=1, enter LOCKED with owner=winner.
- Latency: new q is visible the cycle after the transfer edge. Back-to-back transfers are allowed every cycle.
- LOCKED:
  - grant = one-hot(owner) when req_valid[owner]=1, else 0.
  - Other requesters stall with no grant, regardless of pointer.
  - Owner transfer with req_lock=1: write, stay LOCKED.
  - Owner transfer with req_lock=0: write, go to IDLE. Pointer <= owner+1.
  - Owner with req_valid=0 and req_lock=0: release without write, go to IDLE. Pointer unchanged.
- Requesters hold req_valid and req_data stable until granted. Dropping valid before grant withdraws the request; no error.
- Data width: q is exactly WIDTH bits. No arithmetic on the data.
- NUM_REQ=1: grant[0]=req_valid[0]; lock semantics unchanged.

Optional Feature:
ARB_LOCK_TIMEOUT_EN
- Defined:
  - A counter clears on entry to LOCKED and on every owner transfer. It increments each LOCKED cycle with no owner transfer.
  - When the count reaches LOCK_TIMEOUT-1, the next edge forces IDLE, pointer <= owner+1, and lock_timeout=1 for one cycle. No write occurs.
  - An owner transfer on that same edge takes priority: the write happens and the counter clears.
- Not defined: no counter is built; lock_timeout is tied 0; a lock is held indefinitely.

Test Plan:
- Reset check: assert reset 2 cycles -> q=8'h34, grant=0, wr_strobe=0, locked=0, owner_id=0.
- Fairness: all 4 valid with data A0..A3 held -> grants in order 0,1,2,3 on consecutive cycles; q sequence A0,A1,A2,A3 each one cycle after its grant; wr_strobe high 4 cycles.
- Wrap: pointer=3, req_valid=4'b0011 -> grant=4'b0001, then 4'b0010.
- Lock: req 2 writes 8'h11 with lock=1 while req 0 valid -> locked=1, grant[0] stays 0; req 2 writes 8'h22 lock=0 -> q=8'h22, locked=0, req 0 granted next cycle.
- Reset mid-lock: owner 1 locked, assert reset -> state IDLE, q=8'h34, pointer=0; req 0 and 1 valid -> req 0 granted first.
- With ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=4: owner 3 locks then idles valid=0, lock=1 -> after 4 LOCKED cycles lock_timeout pulses, locked=0, q unchanged.
